mux2_rr_arbiter: RTL and testbench

Round-robin arbiter and sequencer for a shared 2:1 data mux. Two requesters each present a valid/ready stream. The block decides which source drives the mux select and registers the selected beat onto one shared output stream. It enforces a burst limit so neither requester can starve the other, and sits between two producer blocks and one shared downstream consumer.

---
 rtl/mux2_rr_arbiter_if.sv | 36 +++
 rtl/mux2_rr_arbiter.sv | 133 +++++++++++++
 tb/tb_mux2_rr_arbiter.sv | 225 ++++++++++++++++++++++
 3 files changed

// File: rtl/mux2_rr_arbiter_if.sv
//------------------------------------------------------------------------------
// Module   : mux2_rr_arbiter_if
// Brief    : Two requester streams, one shared output stream and the grant vector.
// Revision : 1.0
//------------------------------------------------------------------------------
`default_nettype none

interface mux2_rr_arbiter_if #(
   parameter int DATA_W = 8
);
   logic              in0_valid;
   logic [DATA_W-1:0] in0_data;
   logic              in0_ready;
   logic              in1_valid;
   logic [DATA_W-1:0] in1_data;
   logic              in1_ready;
   logic              out_valid;
   logic [DATA_W-1:0] out_data;
   logic              out_src;
   logic              out_ready;
   logic [1:0]        grant;

   // Arbiter side
   modport slave (
      input  in0_valid, in0_data, in1_valid, in1_data, out_ready,
      output in0_ready, in1_ready, out_valid, out_data, out_src, grant
   );

   // Producer/consumer side
   modport master (
      output in0_valid, in0_data, in1_valid, in1_data, out_ready,
      input  in0_ready, in1_ready, out_valid, out_data, out_src, grant
   );
endinterface

`default_nettype wire

// File: rtl/mux2_rr_arbiter.sv
//------------------------------------------------------------------------------
// Module   : mux2_rr_arbiter
// Brief    : Round-robin arbiter with burst limit feeding a registered 2:1 mux.
// Revision : 1.0
//------------------------------------------------------------------------------
`default_nettype none

module mux2_rr_arbiter #(
   parameter int DATA_W    = 8,
   parameter int MAX_BURST = 4
) (
   input  logic                clk,
   input  logic                rst_n,
   mux2_rr_arbiter_if.slave    arb_io
);

   localparam logic [1:0] c_IDLE      = 2'd0;
   localparam logic [1:0] c_GNT0      = 2'd1;
   localparam logic [1:0] c_GNT1      = 2'd2;
   localparam logic [7:0] c_MAX_BURST = 8'(MAX_BURST);

   logic [1:0]        state_q,     state_d;
   logic              last_q,      last_d;
   logic [7:0]        beat_cnt_q,  beat_cnt_d;
   logic              out_valid_q, out_valid_d;
   logic [DATA_W-1:0] out_data_q,  out_data_d;
   logic              out_src_q,   out_src_d;

   logic              space;
   logic              rdy0;
   logic              rdy1;
   logic              acc0;
   logic              acc1;
   logic              burst_done;
   logic [7:0]        beat_cnt_inc;

   // Output register can take a beat if empty or draining this cycle
   assign space        = !out_valid_q || arb_io.out_ready;
   assign rdy0         = (state_q == c_GNT0) && space;
   assign rdy1         = (state_q == c_GNT1) && space;
   assign acc0         = arb_io.in0_valid && rdy0;
   assign acc1         = arb_io.in1_valid && rdy1;
   assign beat_cnt_inc = beat_cnt_q + 8'd1;
   assign burst_done   = (beat_cnt_inc == c_MAX_BURST);

   always_comb begin
      state_d = state_q;
      last_d  = last_q;
      case (state_q)
         c_IDLE: begin
            if (arb_io.in0_valid && arb_io.in1_valid) begin
               state_d = last_q ? c_GNT0 : c_GNT1;
            end else if (arb_io.in0_valid) begin
               state_d = c_GNT0;
            end else if (arb_io.in1_valid) begin
               state_d = c_GNT1;
            end
         end
         c_GNT0: begin
            if (!arb_io.in0_valid) begin
               state_d = arb_io.in1_valid ? c_GNT1 : c_IDLE;
               last_d  = 1'b0;
            end else if (acc0 && burst_done && arb_io.in1_valid) begin
               state_d = c_GNT1;
               last_d  = 1'b0;
            end
         end
         c_GNT1: begin
            if (!arb_io.in1_valid) begin
               state_d = arb_io.in0_valid ? c_GNT0 : c_IDLE;
               last_d  = 1'b1;
            end else if (acc1 && burst_done && arb_io.in0_valid) begin
               state_d = c_GNT0;
               last_d  = 1'b1;
            end
         end
         default: begin
            state_d = c_IDLE;
         end
      endcase
   end

   // Burst counter restarts on any ownership change or when the limit is reached
   always_comb begin
      beat_cnt_d = beat_cnt_q;
      if (state_d != state_q) begin
         beat_cnt_d = 8'd0;
      end else if (acc0 || acc1) begin
         beat_cnt_d = burst_done ? 8'd0 : beat_cnt_inc;
      end
   end

   always_comb begin
      out_valid_d = out_valid_q;
      out_data_d  = out_data_q;
      out_src_d   = out_src_q;
      if (acc0 || acc1) begin
         out_valid_d = 1'b1;
         out_data_d  = acc1 ? arb_io.in1_data : arb_io.in0_data;
         out_src_d   = acc1;
      end else if (arb_io.out_ready) begin
         out_valid_d = 1'b0;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q     <= c_IDLE;
         last_q      <= 1'b1;
         beat_cnt_q  <= 8'd0;
         out_valid_q <= 1'b0;
         out_data_q  <= '0;
         out_src_q   <= 1'b0;
      end else begin
         state_q     <= state_d;
         last_q      <= last_d;
         beat_cnt_q  <= beat_cnt_d;
         out_valid_q <= out_valid_d;
         out_data_q  <= out_data_d;
         out_src_q   <= out_src_d;
      end
   end

   assign arb_io.in0_ready = rdy0;
   assign arb_io.in1_ready = rdy1;
   assign arb_io.out_valid = out_valid_q;
   assign arb_io.out_data  = out_data_q;
   assign arb_io.out_src   = out_src_q;
   assign arb_io.grant     = {state_q == c_GNT1, state_q == c_GNT0};

endmodule

`default_nettype wire

// File: tb/tb_mux2_rr_arbiter.sv
//------------------------------------------------------------------------------
// Module   : tb_mux2_rr_arbiter
// Brief    : Directed bench for mux2_rr_arbiter with hand-computed expectations.
// Revision : 1.0
//------------------------------------------------------------------------------
`default_nettype none

module tb_mux2_rr_arbiter;

   logic clk;
   logic rst_n;
   int   chk_cnt;
   int   err_cnt;

   mux2_rr_arbiter_if #(.DATA_W(8)) u_if ();

   mux2_rr_arbiter #(
      .DATA_W    (8),
      .MAX_BURST (4)
   ) u_dut (
      .clk    (clk),
      .rst_n  (rst_n),
      .arb_io (u_if.slave)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Burst of 4 from in0, 4 from in1, then back to in0
   logic [7:0] t3_data [9] = '{8'hA0, 8'hA1, 8'hA2, 8'hA3, 8'hB0, 8'hB1, 8'hB2, 8'hB3, 8'hA4};
   logic       t3_src  [9] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0};

   // in1 stream with a three-cycle output stall
   logic       t4_or   [9] = '{1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1};
   logic       t4_rdy  [9] = '{1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1};
   logic       t4_ov   [9] = '{1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1};
   logic [7:0] t4_od   [9] = '{8'h00, 8'hC0, 8'hC1, 8'hC1, 8'hC1, 8'hC1, 8'hC2, 8'hC3, 8'hC4};

   task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
      chk_cnt++;
      if (got !== exp) begin
         err_cnt++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   task automatic cyc();
      @(posedge clk);
      #1;
   endtask

   initial begin
      logic [7:0] a;
      logic [7:0] b;
      logic       acc0;
      logic       acc1;

      chk_cnt = 0;
      err_cnt = 0;
      rst_n          = 1'b0;
      u_if.in0_valid = 1'b0;
      u_if.in0_data  = 8'h00;
      u_if.in1_valid = 1'b0;
      u_if.in1_data  = 8'h00;
      u_if.out_ready = 1'b0;

      // Reset state and idle after release
      cyc();
      cyc();
      check_eq("rst_grant",     u_if.grant,     2'b00);
      check_eq("rst_out_valid", u_if.out_valid, 1'b0);
      check_eq("rst_out_data",  u_if.out_data,  8'h00);
      check_eq("rst_out_src",   u_if.out_src,   1'b0);
      check_eq("rst_rdy0",      u_if.in0_ready, 1'b0);
      check_eq("rst_rdy1",      u_if.in1_ready, 1'b0);
      u_if.out_ready = 1'b1;
      rst_n          = 1'b1;
      for (int i = 0; i < 5; i++) begin
         cyc();
         check_eq("idle_grant",     u_if.grant,     2'b00);
         check_eq("idle_out_valid", u_if.out_valid, 1'b0);
         check_eq("idle_rdy0",      u_if.in0_ready, 1'b0);
         check_eq("idle_rdy1",      u_if.in1_ready, 1'b0);
      end

      // Single requester 0, three beats
      u_if.in0_valid = 1'b1;
      u_if.in0_data  = 8'h11;
      #1;
      check_eq("t2_arb_grant", u_if.grant,     2'b00);
      check_eq("t2_arb_rdy0",  u_if.in0_ready, 1'b0);
      cyc();
      check_eq("t2_grant",     u_if.grant,     2'b01);
      check_eq("t2_rdy0",      u_if.in0_ready, 1'b1);
      check_eq("t2_ov0",       u_if.out_valid, 1'b0);
      cyc();
      check_eq("t2_ov1",       u_if.out_valid, 1'b1);
      check_eq("t2_od1",       u_if.out_data,  8'h11);
      check_eq("t2_src1",      u_if.out_src,   1'b0);
      u_if.in0_data = 8'h22;
      cyc();
      check_eq("t2_od2",       u_if.out_data,  8'h22);
      u_if.in0_data = 8'h33;
      cyc();
      check_eq("t2_od3",       u_if.out_data,  8'h33);
      check_eq("t2_src3",      u_if.out_src,   1'b0);
      u_if.in0_valid = 1'b0;
      cyc();
      check_eq("t2_end_grant", u_if.grant,     2'b00);
      check_eq("t2_end_ov",    u_if.out_valid, 1'b0);

      // Re-reset so requester 0 wins the first tie
      rst_n = 1'b0;
      cyc();
      rst_n = 1'b1;

      // Both requesters streaming: burst alternation
      a = 8'd0;
      b = 8'd0;
      u_if.in0_valid = 1'b1;
      u_if.in1_valid = 1'b1;
      for (int c = 0; c < 10; c++) begin
         u_if.in0_data = 8'hA0 + a;
         u_if.in1_data = 8'hB0 + b;
         #1;
         acc0 = u_if.in0_ready;
         acc1 = u_if.in1_ready;
         check_eq("t3_rdy_excl", {31'd0, acc0 & acc1}, 32'd0);
         cyc();
         if (acc0) a++;
         if (acc1) b++;
         if (c == 0) check_eq("t3_grant_first", u_if.grant, 2'b01);
         if (c == 4) check_eq("t3_grant_sw1",   u_if.grant, 2'b10);
         if (c == 8) check_eq("t3_grant_sw0",   u_if.grant, 2'b01);
         if (c >= 1) begin
            check_eq("t3_ov",  u_if.out_valid, 1'b1);
            check_eq("t3_od",  u_if.out_data,  t3_data[c-1]);
            check_eq("t3_src", u_if.out_src,   t3_src[c-1]);
         end
      end
      u_if.in0_valid = 1'b0;
      u_if.in1_valid = 1'b0;
      cyc();
      check_eq("t3_end_grant", u_if.grant, 2'b00);

      // in1 streaming with output back-pressure
      b = 8'd0;
      u_if.in1_valid = 1'b1;
      for (int c = 0; c < 9; c++) begin
         u_if.out_ready = t4_or[c];
         u_if.in1_data  = 8'hC0 + b;
         #1;
         acc1 = u_if.in1_ready;
         check_eq("t4_rdy1", u_if.in1_ready, t4_rdy[c]);
         check_eq("t4_rdy0", u_if.in0_ready, 1'b0);
         cyc();
         if (acc1) b++;
         check_eq("t4_ov", u_if.out_valid, t4_ov[c]);
         if (t4_ov[c]) begin
            check_eq("t4_od",  u_if.out_data, t4_od[c]);
            check_eq("t4_src", u_if.out_src,  1'b1);
         end
      end
      check_eq("t4_grant", u_if.grant, 2'b10);

      // Owner drops valid while the other requests
      u_if.out_ready = 1'b1;
      u_if.in1_valid = 1'b0;
      u_if.in0_valid = 1'b1;
      u_if.in0_data  = 8'hD0;
      cyc();
      check_eq("t5_grant0", u_if.grant,     2'b01);
      check_eq("t5_ov",     u_if.out_valid, 1'b0);
      u_if.in0_valid = 1'b0;
      u_if.in1_valid = 1'b1;
      cyc();
      check_eq("t5_grant1", u_if.grant,     2'b10);
      check_eq("t5_ov1",    u_if.out_valid, 1'b0);
      u_if.in1_valid = 1'b0;
      cyc();
      check_eq("t5_idle",   u_if.grant,     2'b00);

      // Leave last=0 so a surviving arbitration history would favour in1
      u_if.in0_valid = 1'b1;
      cyc();
      check_eq("t6_grant0", u_if.grant, 2'b01);
      u_if.in0_valid = 1'b0;
      cyc();
      check_eq("t6_idle",   u_if.grant, 2'b00);
      u_if.in1_valid = 1'b1;
      u_if.in1_data  = 8'hE5;
      cyc();
      check_eq("t6_grant1", u_if.grant, 2'b10);
      cyc();
      check_eq("t6_ov",     u_if.out_valid, 1'b1);
      check_eq("t6_od",     u_if.out_data,  8'hE5);
      check_eq("t6_src",    u_if.out_src,   1'b1);

      // Asynchronous reset between clock edges
      #2;
      rst_n = 1'b0;
      #1;
      check_eq("t6_async_ov",    u_if.out_valid, 1'b0);
      check_eq("t6_async_grant", u_if.grant,     2'b00);
      check_eq("t6_async_od",    u_if.out_data,  8'h00);
      check_eq("t6_async_src",   u_if.out_src,   1'b0);
      check_eq("t6_async_rdy1",  u_if.in1_ready, 1'b0);
      u_if.in0_valid = 1'b1;
      u_if.in1_valid = 1'b1;
      cyc();
      check_eq("t6_hold_grant",  u_if.grant,     2'b00);
      rst_n = 1'b1;
      cyc();
      check_eq("t6_tie_grant",   u_if.grant,     2'b01);
      u_if.in0_valid = 1'b0;
      u_if.in1_valid = 1'b0;
      cyc();

      $display("Result: errors=%0d of %0d checks", err_cnt, chk_cnt);
      $finish;
   end

endmodule

`default_nettype wire
